// File: rtl/seq_magnitude_comp.sv
// seq_magnitude_comp: multi-cycle MSB-first magnitude comparator, DIGIT bits per clock,
// unsigned or two's-complement, with early exit on the first differing digit.
module seq_magnitude_comp #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             G,
    output logic             L,
    output logic             E
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b;
    logic [IW-1:0]    r_idx;
    logic             r_signed, r_busy, r_done, r_g, r_l, r_e;
    logic             w_top;
    logic [DIGIT-1:0] w_flip, w_da, w_db;
    // Inverting the sign bit on the top digit turns a signed compare into an unsigned one
    assign w_top  = r_signed && (r_idx == IW'(NDIG - 1));
    assign w_flip = DIGIT'(w_top) << (DIGIT - 1);
    assign w_da   = r_a[r_idx * DIGIT +: DIGIT] ^ w_flip;
    assign w_db   = r_b[r_idx * DIGIT +: DIGIT] ^ w_flip;
    assign busy   = r_busy;
    assign done   = r_done;
    assign G      = r_g;
    assign L      = r_l;
    assign E      = r_e;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_signed <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_g      <= 1'b0;
            r_l      <= 1'b0;
            r_e      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_signed <= signed_mode;
                        r_idx    <= IW'(NDIG - 1);
                        r_busy   <= 1'b1;
                        r_state  <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_da != w_db || r_idx == '0) begin
                        r_g     <= w_da > w_db;
                        r_l     <= w_da < w_db;
                        r_e     <= w_da == w_db;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_magnitude_comp.sv
// tb_seq_magnitude_comp: scoreboard bench over DIGIT = 1, 2, 4, 16 instances at WIDTH = 16.
module tb_seq_magnitude_comp;
    localparam int W = 16;
    typedef struct {
        int   id;
        logic g, l, e;
        int   lat;
        int   t0;
    } exp_t;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   st = '0, sm = '0, busy_v, done_v, g_v, l_v, e_v;
    logic [W-1:0] av[4], bv[4];
    int           cyc = 0, checks = 0, errors = 0;
    exp_t         q[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    for (genvar k = 0; k < 4; k++) begin : g_dut
        seq_magnitude_comp #(.WIDTH(W), .DIGIT(k == 0 ? 1 : k == 1 ? 2 : k == 2 ? 4 : 16)) u_dut (
            .clk(clk), .rst(rst), .start(st[k]), .signed_mode(sm[k]), .a(av[k]), .b(bv[k]),
            .busy(busy_v[k]), .done(done_v[k]), .G(g_v[k]), .L(l_v[k]), .E(e_v[k]));
    end
    function automatic int dig(int id);
        return id == 0 ? 1 : id == 1 ? 2 : id == 2 ? 4 : 16;
    endfunction
    function automatic exp_t model(int id, logic s, logic [W-1:0] a, logic [W-1:0] b);
        exp_t x;
        int d = dig(id), n = W / dig(id), k = 0;
        logic [31:0] aa = 32'(a), bb = 32'(b), m = (32'd1 << d) - 1;
        x.id = id;
        x.g = s ? ($signed(a) > $signed(b)) : (a > b);
        x.l = s ? ($signed(a) < $signed(b)) : (a < b);
        x.e = a == b;
        while (k < n - 1 && ((aa >> ((n - 1 - k) * d)) & m) == ((bb >> ((n - 1 - k) * d)) & m)) k++;
        x.lat = k + 2;
        x.t0 = cyc;
        return x;
    endfunction
    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (done_v[k] === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done instance %0d at cycle %0d", k, cyc);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("instance", k, x.id);
                    chk("flags_GLE", {g_v[k], l_v[k], e_v[k]}, {x.g, x.l, x.e});
                    chk("latency", cyc - x.t0, x.lat);
                    chk("busy_at_done", busy_v[k], 0);
                end
            end
        end
    end
    task automatic run(int id, logic s, logic [W-1:0] a, logic [W-1:0] b, bit push);
        @(negedge clk);
        st[id] = 1'b1;
        sm[id] = s;
        av[id] = a;
        bv[id] = b;
        if (push) q.push_back(model(id, s, a, b));
        @(negedge clk);
        st[id] = 1'b0;
        sm[id] = ~s;
        av[id] = W'($urandom);
        bv[id] = W'($urandom);
    endtask
    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for done, %0d results outstanding", q.size());
            q.delete();
        end
    endtask
    task automatic compare(int id, logic s, logic [W-1:0] a, logic [W-1:0] b);
        run(id, s, a, b, 1);
        wait_done();
    endtask
    initial begin
        for (int k = 0; k < 4; k++) begin
            av[k] = 16'h1234;
            bv[k] = 16'h4321;
        end
        st = 4'hF;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy_v, 0);
        chk("reset_done", done_v, 0);
        chk("reset_G", g_v, 0);
        chk("reset_L", l_v, 0);
        chk("reset_E", e_v, 0);
        rst = 1'b0;
        st = '0;
        compare(1, 0, 16'hA5A5, 16'hA5A5);
        repeat (5) begin
            @(negedge clk);
            chk("hold_GLE", {g_v[1], l_v[1], e_v[1]}, 3'b001);
            chk("hold_busy", busy_v[1], 0);
        end
        compare(1, 0, 16'h8000, 16'h7FFF);
        compare(1, 1, 16'h8000, 16'h7FFF);
        compare(1, 0, 16'h0001, 16'h0002);
        compare(1, 1, 16'hFFFF, 16'hFFFE);
        run(1, 0, 16'h0100, 16'h0100, 1);
        st[1] = 1'b1;
        sm[1] = 1'b1;
        av[1] = 16'hFFFF;
        bv[1] = 16'h0000;
        @(negedge clk);
        st[1] = 1'b0;
        wait_done();
        compare(1, 0, 16'h0003, 16'h0003);
        st[1] = 1'b1;
        av[1] = 16'h0005;
        bv[1] = 16'h0009;
        @(negedge clk);
        st[1] = 1'b0;
        repeat (12) @(negedge clk);
        chk("start_in_done_ignored", busy_v[1], 0);
        for (int i = 0; i < 6; i++) compare(1, i[0], W'($urandom), W'($urandom));
        run(1, 0, 16'h1234, 16'h1234, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy_v[1], 0);
        chk("abort_done", done_v[1], 0);
        chk("abort_GLE", {g_v[1], l_v[1], e_v[1]}, 0);
        repeat (12) @(negedge clk);
        chk("abort_idle", busy_v[1], 0);
        for (int id = 0; id < 4; id++) begin
            for (int i = 0; i < 1000; i++) begin
                logic [W-1:0] ra, rb;
                ra = W'($urandom);
                case ($urandom_range(0, 2))
                    0: rb = W'($urandom);
                    1: rb = ra;
                    default: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                endcase
                compare(id, 1'($urandom), ra, rb);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_magnitude_comp.md
Name: seq_magnitude_comp

Overview:
- Parametrised, multi-cycle successor to the team's 2-bit comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, in unsigned or two's-complement mode.
- Terminates early on the first differing digit.
- Uses a start/busy/done handshake, so slow wide compares sit off the critical path of the datapath that feeds it.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits compared per cycle (the 2-bit compare cell); 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with the operands.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- G  output  1  A > B.
- L  output  1  A < B.
- E  output  1  A == B.

Behaviour:
- Reset (rst=1 at a clock edge) forces: state=IDLE, busy=0, done=0, G=L=E=0, digit index=0, operand registers=0.
- Reset wins over every other input in the same cycle, including during COMPARE. An aborted compare never asserts done.
- States: IDLE, COMPARE, DONE.
- IDLE:
  - start=1 latches a, b and signed_mode, sets index to the top digit (NDIG-1, where NDIG=WIDTH/DIGIT), and goes to COMPARE.
  - busy=1 from the next cycle.
  - G/L/E keep their previous result until the new result is written.
- COMPARE: each cycle, compare digit [index*DIGIT +: DIGIT] of A and B as unsigned DIGIT-bit values.
  - Signed mode, top digit only: invert bit WIDTH-1 of both operands before comparing, so a negative operand ranks below a non-negative one.
  - Digits differ: write G or L (the other two flags 0) and go to DONE.
  - Digits equal and index==0: write E=1, G=L=0, go to DONE.
  - Digits equal and index>0: decrement index and stay in COMPARE.
- DONE: done=1 and busy=0 for exactly this cycle, then return to IDLE.
  - G/L/E hold until the next accepted start's result, or until reset.
  - A start asserted in the DONE cycle is ignored. It must be re-asserted in IDLE.
- Latency, from the start edge to the done cycle: k+2 cycles, where k (0..NDIG-1) is the number of equal leading digits.
  - Minimum: 2 cycles.
  - Maximum: NDIG+1 cycles (equal operands, or operands differing only in digit 0).
- A start asserted while busy=1 or in DONE is ignored. Operand inputs may change freely after the accept cycle.
- Invariant: after the first done, exactly one of G/L/E is 1. Before the first done, all three are 0.
- DIGIT==WIDTH degenerates to a single-cycle compare, with latency 2.

Test Plan:
- Reset behaviour: rst=1 for 2 cycles with start=1 → busy=0, done=0, G=L=E=0. Assert rst during COMPARE (WIDTH=16, DIGIT=2, a=b=16'h1234) → next cycle IDLE, done never pulses, G=L=E=0.
- Equal operands: a=b=16'hA5A5, unsigned → done exactly 9 cycles after the start edge (NDIG=8), E=1, G=L=0. The flags stay held for 5 idle cycles afterwards.
- Early termination: a=16'h8000, b=16'h7FFF, unsigned → done at cycle 2, G=1. The same operands with signed_mode=1 → done at cycle 2, L=1 (-32768 < 32767).
- Low-digit difference: a=16'h0001, b=16'h0002, unsigned → done at cycle 9, L=1. a=16'hFFFF, b=16'hFFFE, signed → done at cycle 9, G=1 (-1 > -2).
- Handshake: pulse start again during busy with different operands → ignored; the result matches the first operands. Back-to-back starts, each issued in IDLE → every start gets exactly one done pulse.
- Parameter sweep: DIGIT ∈ {1, 2, 4, 16}, WIDTH=16, 1000 random operand pairs in both modes → G/L/E match a reference compare; latency = 2 + leading-equal-digit count.
